// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART packet framer.
//   fsm_state_t    - framer state encoding (LOAD / SEND / WAIT)
//   DEFAULT_HEADER - default start-of-frame byte
//   CRC8_POLY      - CRC-8 polynomial (x^8 + x^2 + x + 1)
//   crc8_step      - one byte of CRC-8, MSB-first, no reflection
package uart_pkg;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } fsm_state_t;

  localparam logic [7:0] DEFAULT_HEADER = 8'hA5;
  localparam logic [7:0] CRC8_POLY      = 8'h07;

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// uart_frame_buf: MAX_LEN x 8 payload register buffer.
//   clk, rst_n  - clock, asynchronous active-low reset (clears the count)
//   wr_en       - write wr_data at position cnt, then increment cnt
//   wr_data     - payload byte
//   clr         - return cnt to zero (frame finished)
//   rd_addr     - combinational read address; out-of-range reads return 0
//   rd_data     - byte at rd_addr
//   cnt         - number of bytes written since the last clear
module uart_frame_buf #(
  parameter int MAX_LEN = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       clr,
  input  logic [7:0] rd_addr,
  output logic [7:0] rd_data,
  output logic [7:0] cnt
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  // Storage is rounded up to a power of two so every address slice is in range.
  logic [7:0] mem [2**AW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 8'd0;
    end else if (clr) begin
      cnt <= 8'd0;
    end else if (wr_en) begin
      cnt <= cnt + 8'd1;
    end
  end

  // Payload contents need no reset: cnt gates what is ever read back.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[cnt[AW-1:0]] <= wr_data;
    end
  end

  assign rd_data = (32'(rd_addr) < MAX_LEN) ? mem[rd_addr[AW-1:0]] : 8'h00;

endmodule

// File: rtl/uart_tx_framer.sv
// uart_tx_framer: buffers a client payload, then drives a byte-level UART
// transmitter with HEADER, LEN, payload bytes and a check byte.
// Optional feature macro: UART_FRAME_CRC8_EN selects a CRC-8 check byte
// (poly 0x07, init 0, over LEN then payload); otherwise the check byte is
// (LEN + sum of payload) mod 256.
// Ports:
//   sclk, rst_n   - clock, asynchronous active-low reset
//   wr_data_i     - payload byte; wr_en_i valid; wr_last_i marks final byte
//   wr_ready_o    - high in LOAD; a byte transfers on wr_en_i & wr_ready_o
//   tx_data_o     - byte to the transmitter, stable until its completion
//   tx_en_o       - one-cycle start pulse per byte
//   tx_done_i     - one-cycle completion pulse, honoured only in WAIT
//   busy_o        - frame transmission in progress
//   frame_done_o  - pulse when the check byte completes
//   trunc_o       - pulse when the frame closes at MAX_LEN without wr_last_i
//   state_dbg     - current FSM state (fsm_state_t encoding)
// Handshake: the payload side is valid/ready (transfer when both are high in
// the same cycle); the transmitter side is pulse-based: tx_en_o starts a byte
// and the next byte is issued only after tx_done_i is seen in WAIT.
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int         MAX_LEN = 16,
  parameter logic [7:0] HEADER  = DEFAULT_HEADER
) (
  input  logic       sclk,
  input  logic       rst_n,
  input  logic [7:0] wr_data_i,
  input  logic       wr_en_i,
  input  logic       wr_last_i,
  output logic       wr_ready_o,
  output logic [7:0] tx_data_o,
  output logic       tx_en_o,
  input  logic       tx_done_i,
  output logic       busy_o,
  output logic       frame_done_o,
  output logic       trunc_o,
  output logic [1:0] state_dbg
);

  fsm_state_t state_q, state_d;
  logic [8:0] idx_q, idx_d;     // frame byte index, up to len+2 (257 max)
  logic [7:0] len_q, len_d;
  logic [7:0] chk_q;
  logic [7:0] cnt, rd_addr, rd_data;
  logic       buf_wr, buf_clr, close, load_tx;
  logic       tx_en_d, fdone_d, trunc_d;
  logic [7:0] tx_data_d, byte_sel, check_byte;

  uart_frame_buf #(.MAX_LEN(MAX_LEN)) u_buf (
    .clk     (sclk),
    .rst_n   (rst_n),
    .wr_en   (buf_wr),
    .wr_data (wr_data_i),
    .clr     (buf_clr),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .cnt     (cnt)
  );

  assign state_dbg = state_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    buf_wr  = 1'b0;
    buf_clr = 1'b0;
    close   = 1'b0;
    load_tx = 1'b0;
    tx_en_d = 1'b0;
    fdone_d = 1'b0;
    trunc_d = 1'b0;
    case (state_q)
      ST_LOAD: begin
        buf_wr = wr_en_i & wr_ready_o;
        // Every close accompanies an accepted byte, so len is never zero.
        if (buf_wr && (wr_last_i || (({1'b0, cnt} + 9'd1) == 9'(MAX_LEN)))) begin
          close   = 1'b1;
          len_d   = cnt + 8'd1;
          idx_d   = 9'd0;
          state_d = ST_SEND;
          load_tx = 1'b1;
          tx_en_d = 1'b1;
          trunc_d = ~wr_last_i;
        end
      end
      ST_SEND: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (tx_done_i) begin
          if (idx_q == ({1'b0, len_q} + 9'd2)) begin
            fdone_d = 1'b1;
            buf_clr = 1'b1;
            state_d = ST_LOAD;
          end else begin
            idx_d   = idx_q + 9'd1;
            state_d = ST_SEND;
            load_tx = 1'b1;
            tx_en_d = 1'b1;
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

`ifdef UART_FRAME_CRC8_EN
  // The CRC walks the buffer in the idle cycles of SEND/WAIT; the read port
  // is lent to the transmit path only on the cycle a byte is loaded.
  logic [7:0] crc_pos;
  logic       crc_step;
  assign crc_step   = (state_q != ST_LOAD) && !load_tx && (crc_pos < len_q);
  assign rd_addr    = load_tx ? 8'(idx_d - 9'd2) : crc_pos;
  assign check_byte = chk_q;
`else
  assign rd_addr    = 8'(idx_d - 9'd2);
  assign check_byte = len_q + chk_q;
`endif

  always_comb begin
    if (idx_d == 9'd0) begin
      byte_sel = HEADER;
    end else if (idx_d == 9'd1) begin
      byte_sel = len_d;
    end else if (idx_d == ({1'b0, len_d} + 9'd2)) begin
      byte_sel = check_byte;
    end else begin
      byte_sel = rd_data;
    end
  end

  assign tx_data_d = load_tx ? byte_sel : tx_data_o;

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_LOAD;
      idx_q        <= 9'd0;
      len_q        <= 8'd0;
      chk_q        <= 8'd0;
      tx_en_o      <= 1'b0;
      tx_data_o    <= 8'h00;
      wr_ready_o   <= 1'b1;
      busy_o       <= 1'b0;
      frame_done_o <= 1'b0;
      trunc_o      <= 1'b0;
`ifdef UART_FRAME_CRC8_EN
      crc_pos      <= 8'd0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      len_q        <= len_d;
      tx_en_o      <= tx_en_d;
      tx_data_o    <= tx_data_d;
      wr_ready_o   <= (state_d == ST_LOAD);
      busy_o       <= (state_d != ST_LOAD);
      frame_done_o <= fdone_d;
      trunc_o      <= trunc_d;
      if (fdone_d) begin
        chk_q <= 8'd0;
`ifdef UART_FRAME_CRC8_EN
      end else if (close) begin
        chk_q   <= crc8_step(8'h00, len_d);
        crc_pos <= 8'd0;
      end else if (crc_step) begin
        chk_q   <= crc8_step(chk_q, rd_data);
        crc_pos <= crc_pos + 8'd1;
`else
      end else if (buf_wr) begin
        chk_q <= chk_q + wr_data_i;
`endif
      end
    end
  end

endmodule
